// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial transmit/receive blocks.
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Serial two's-complement: search for the first 1, then invert the rest.
    typedef enum logic {
        CS_SEARCH = 1'b0,
        CS_INVERT = 1'b1
    } cs_t;

endpackage

// File: rtl/serial_word_tx_if.sv
// Parallel-in / serial-out handshake bundle for serial_word_tx.
interface serial_word_tx_if
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_negate;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    modport master (
        output in_valid, in_data, in_negate, sout_ready,
        input  in_ready, sout, sout_valid, sout_first, sout_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_negate, sout_ready,
        output in_ready, sout, sout_valid, sout_first, sout_last, busy
    );

endinterface

// File: rtl/serial_negate_cell.sv
// One-bit Mealy cell for LSB-first negation: pass bits up to the first 1, invert later bits.
module serial_negate_cell
    import serial_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic neg,
    input  logic bit_in,
    output logic bit_out
);

    cs_t cs;
    cs_t cs_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs <= CS_SEARCH;
        end else begin
            cs <= cs_next;
        end
    end

    // The flag tracks the raw input bit so it is independent of neg.
    always_comb begin
        cs_next = cs;
        if (clear) begin
            cs_next = CS_SEARCH;
        end else if (enable && bit_in) begin
            cs_next = CS_INVERT;
        end
        bit_out = bit_in ^ (neg && (cs == CS_INVERT));
    end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB-first, with optional on-the-fly negation.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    serial_word_tx_if.slave  bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             neg_r;
    logic             beat;
    logic             is_last;
    logic             load;
    logic             cell_bit;

    assign is_last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next      = state;
        beat            = 1'b0;
        load            = 1'b0;
        bus.in_ready    = 1'b0;
        bus.sout_valid  = 1'b0;
        bus.busy        = 1'b0;
        bus.sout_first  = 1'b0;
        bus.sout_last   = 1'b0;
        bus.sout        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                load         = bus.in_valid;
                if (load) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.sout_valid = 1'b1;
                bus.busy       = 1'b1;
                bus.sout_first = (cnt == '0);
                bus.sout_last  = is_last;
                bus.sout       = cell_bit;
                beat           = bus.sout_ready;
                // Accepting the next word on the final beat keeps the stream gap-free.
                bus.in_ready   = beat && is_last;
                load           = bus.in_ready && bus.in_valid;
                if (beat && is_last && !load) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            neg_r <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                shreg <= bus.in_data;
                neg_r <= bus.in_negate;
                cnt   <= '0;
            end else if (beat) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    serial_negate_cell u_negate (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .enable  (beat),
        .neg     (neg_r),
        .bit_in  (shreg[0]),
        .bit_out (cell_bit)
    );

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter. Accepts a WIDTH-bit two's-complement word through a valid/ready handshake and emits it LSB-first, one bit per accepted beat.
- Optionally negates the word on the fly with the bit-serial rule: pass bits up to and including the first 1, invert every later bit.
- Sits upstream of the bit-serial datapath and produces the framed LSB-first stream that the serial complement/arithmetic blocks consume.

Parameters:
- WIDTH, 8, word length in bits; minimum 2.
- CNT_W, $clog2(WIDTH), width of the bit counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block can take a word this cycle.
- in_data  input  WIDTH  two's-complement word.
- in_negate  input  1  sampled with in_data; 1 = transmit -in_data.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is meaningful.
- sout_ready  input  1  downstream consumes sout this cycle.
- sout_first  output  1  current bit is bit 0 of the word.
- sout_last  output  1  current bit is bit WIDTH-1.
- busy  output  1  a word is loaded and not fully sent.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. Reset forces state IDLE, shreg=0, cnt=0, neg_r=0, seen_one=0.
- Output values under reset: sout_valid=0, sout=0, sout_first=0, sout_last=0, busy=0, in_ready=1.
- States: IDLE and SHIFT.
- IDLE: in_ready=1. When in_valid=1:
  - load shreg<=in_data, neg_r<=in_negate, cnt<=0, seen_one<=0.
  - go to SHIFT. sout_valid rises on the next cycle (1-cycle latency).
- SHIFT outputs:
  - sout_valid=1, busy=1.
  - sout_first=(cnt==0), sout_last=(cnt==WIDTH-1).
  - sout = shreg[0] XOR (neg_r AND seen_one). This is a function of registers only; no combinational path from any input to sout.
- A beat is consumed when sout_valid AND sout_ready. On a consumed beat:
  - shreg shifts right by 1, with 0 filled at the MSB.
  - cnt increments.
  - seen_one <= seen_one OR shreg[0]. Track the raw input bit, not sout.
- Stall: sout_ready=0 holds all state. sout, sout_first and sout_last stay stable until the beat is consumed.
- End of word: when the sout_last beat is consumed, return to IDLE, unless a new word is accepted in the same cycle.
- Back-to-back: in_ready = (state==IDLE) OR (sout_valid AND sout_ready AND sout_last).
  - If in_valid=1 in that last-beat cycle, the new word loads and the block stays in SHIFT.
  - No idle bubble between words; the next cycle shows bit 0 of the new word with sout_first=1.
- Arithmetic:
  - negation is modulo 2^WIDTH.
  - 0 negated stays 0; seen_one never sets.
  - The most negative value (100..0) negated is transmitted unchanged.
- in_negate is sampled only at load; changes mid-word are ignored.
- in_data and in_valid are ignored while in SHIFT, except at the last-beat acceptance point.
- Reset mid-word: the word is dropped, with no partial completion. sout_valid falls asynchronously with rst.
- cnt never exceeds WIDTH-1; there is no wrap within a word.

Decomposition:
- Shared package serial_pkg:
  - state encodings: ST_IDLE, ST_SHIFT.
  - complement encodings: CS_SEARCH, CS_INVERT, for the seen_one flag.
  - default WIDTH constant.
- One natural sub-module: serial_negate_cell.
  - Holds the 1-bit Mealy search/invert flag.
  - Inputs: clk, rst, clear, enable, neg, bit_in. Output: bit_out.
  - serial_word_tx instantiates it, with clear=load and enable=beat consumed.
  - The same cell is reusable by the serial receiver side.
- Remainder of the block: shift register, counter, handshake logic.

Test Plan (WIDTH=8):
- Pass-through: load 0x06, negate=0, sout_ready=1.
  - Required: 8 consecutive bits 0,1,1,0,0,0,0,0.
  - first=1 on beat 0 only; last=1 on beat 7 only.
  - sout_valid appears 1 cycle after acceptance.
- Negate: load 0x06, negate=1.
  - Required bits 0,1,0,1,1,1,1,1, i.e. 0xFA.
- Boundary values with negate=1:
  - 0x00 → all 0.
  - 0x80 → 0,0,0,0,0,0,0,1.
  - 0x01 → 1,1,1,1,1,1,1,1.
- Back-to-back with backpressure:
  - Words 0x35 and 0xC2 offered continuously, sout_ready toggled 1,0,1,0.
  - sout/first/last stay stable across stalls.
  - in_ready=1 exactly on the consumed last beat.
  - 0xC2 bit 0 follows with no gap; 16 consumed beats total.
- Reset mid-word: assert rst after beat 3 of 0x5A.
  - sout_valid=0 and in_ready=1 immediately.
  - After release, load 0x0F negate=1 → 1,0,0,0,1,1,1,1 (0xF1).
  - No leftover seen_one from the aborted word.
- Late negate change: toggle in_negate during a SHIFT of 0x06 loaded with negate=0.
  - Output is unaffected: 0,1,1,0,0,0,0,0.
